hazard_stall_ctrl: RTL and testbench

Decode-stage hazard controller. It tracks the destination register of every in-flight instruction in EX, MEM and WB, and compares it against the source registers of the instruction in ID. On a read-after-write hazard it drops `pipe_enable`, which drives the `enable` pins of the 3-bit dff_stall-based PC/IF-ID pipeline registers. It also injects a bubble into ID/EX. An optional build adds forwarding-select generation, so that only load-use hazards stall.

---
 rtl/hazard_stall_ctrl_if.sv | 40 ++++
 rtl/hazard_stall_ctrl.sv | 118 +++++++++++
 tb/tb_hazard_stall_ctrl.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/hazard_stall_ctrl_if.sv
// ============================================================================
// Module   : hazard_stall_ctrl_if
// Brief    : Decode-stage source/destination info and stall/forward controls
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface hazard_stall_ctrl_if #(
    parameter int ADDR_W = 3
);
    logic              id_valid;
    logic [ADDR_W-1:0] id_rs;
    logic              id_rs_used;
    logic [ADDR_W-1:0] id_rt;
    logic              id_rt_used;
    logic [ADDR_W-1:0] id_wr_reg;
    logic              id_wr_en;
    logic              id_is_load;
    logic              flush;
    logic              pipe_enable;
    logic              bubble;
    logic [1:0]        fwd_rs_sel;
    logic [1:0]        fwd_rt_sel;
    logic [7:0]        stall_count;

    // ID stage side: presents the decoded instruction, consumes the controls
    modport master (
        output id_valid, id_rs, id_rs_used, id_rt, id_rt_used,
               id_wr_reg, id_wr_en, id_is_load, flush,
        input  pipe_enable, bubble, fwd_rs_sel, fwd_rt_sel, stall_count
    );

    modport slave (
        input  id_valid, id_rs, id_rs_used, id_rt, id_rt_used,
               id_wr_reg, id_wr_en, id_is_load, flush,
        output pipe_enable, bubble, fwd_rs_sel, fwd_rt_sel, stall_count
    );
endinterface

`default_nettype wire

// File: rtl/hazard_stall_ctrl.sv
// ============================================================================
// Module   : hazard_stall_ctrl
// Brief    : RAW hazard stall controller with EX/MEM/WB destination scoreboard.
//            Define HAZARD_STALL_FWD_EN for forwarding-select generation.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module hazard_stall_ctrl #(
    parameter int ADDR_W = 3
) (
    input  wire logic           clk,
    input  wire logic           rst,
    hazard_stall_ctrl_if.slave  hif
);

    localparam logic [7:0] c_CNT_MAX = 8'hFF;

    localparam logic [1:0] c_SEL_RF  = 2'd0;
    localparam logic [1:0] c_SEL_EX  = 2'd1;
    localparam logic [1:0] c_SEL_MEM = 2'd2;
    localparam logic [1:0] c_SEL_WB  = 2'd3;

    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] wr_reg;
        logic              is_load;
    } sb_entry_t;

    sb_entry_t  r_sb_ex;
    sb_entry_t  r_sb_mem;
    sb_entry_t  r_sb_wb;
    logic [7:0] r_stall_count;

    logic w_live;
    logic w_rs_ex, w_rs_mem, w_rs_wb;
    logic w_rt_ex, w_rt_mem, w_rt_wb;
    logic w_hazard;
    logic w_bubble;

    function automatic logic src_match(
        input logic              used,
        input logic [ADDR_W-1:0] src,
        input sb_entry_t         ent
    );
        return used & ent.valid & (ent.wr_reg == src);
    endfunction

    // Youngest producer wins: EX over MEM over WB
    function automatic logic [1:0] fwd_pick(
        input logic m_ex,
        input logic m_mem,
        input logic m_wb
    );
        if (m_ex)       return c_SEL_EX;
        else if (m_mem) return c_SEL_MEM;
        else if (m_wb)  return c_SEL_WB;
        else            return c_SEL_RF;
    endfunction

    assign w_live   = hif.id_valid & ~hif.flush;

    assign w_rs_ex  = src_match(hif.id_rs_used, hif.id_rs, r_sb_ex);
    assign w_rs_mem = src_match(hif.id_rs_used, hif.id_rs, r_sb_mem);
    assign w_rs_wb  = src_match(hif.id_rs_used, hif.id_rs, r_sb_wb);
    assign w_rt_ex  = src_match(hif.id_rt_used, hif.id_rt, r_sb_ex);
    assign w_rt_mem = src_match(hif.id_rt_used, hif.id_rt, r_sb_mem);
    assign w_rt_wb  = src_match(hif.id_rt_used, hif.id_rt, r_sb_wb);

`ifdef HAZARD_STALL_FWD_EN
    // Only a load still in EX cannot be forwarded in time
    assign w_hazard = w_live & r_sb_ex.is_load & (w_rs_ex | w_rt_ex);

    assign hif.fwd_rs_sel = w_bubble ? c_SEL_RF : fwd_pick(w_rs_ex, w_rs_mem, w_rs_wb);
    assign hif.fwd_rt_sel = w_bubble ? c_SEL_RF : fwd_pick(w_rt_ex, w_rt_mem, w_rt_wb);

    logic w_unused_sb;
    assign w_unused_sb = r_sb_mem.is_load ^ r_sb_wb.is_load;
`else
    // Register file has no write-through, so a WB producer still blocks
    assign w_hazard = w_live & (w_rs_ex | w_rs_mem | w_rs_wb |
                                w_rt_ex | w_rt_mem | w_rt_wb);

    assign hif.fwd_rs_sel = c_SEL_RF;
    assign hif.fwd_rt_sel = c_SEL_RF;

    logic w_unused_sb;
    assign w_unused_sb = r_sb_ex.is_load ^ r_sb_mem.is_load ^ r_sb_wb.is_load
                       ^ (^fwd_pick(1'b0, 1'b0, 1'b0));
`endif

    // Flush squashes the ID slot but keeps fetch moving for the redirect
    assign w_bubble        = w_hazard | hif.flush;
    assign hif.bubble      = w_bubble;
    assign hif.pipe_enable = ~w_hazard;
    assign hif.stall_count = r_stall_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sb_ex       <= '0;
            r_sb_mem      <= '0;
            r_sb_wb       <= '0;
            r_stall_count <= '0;
        end else begin
            r_sb_wb  <= r_sb_mem;
            r_sb_mem <= r_sb_ex;
            r_sb_ex  <= {hif.id_valid & hif.id_wr_en & ~w_bubble,
                         hif.id_wr_reg,
                         hif.id_is_load};
            if (w_hazard && (r_stall_count != c_CNT_MAX)) begin
                r_stall_count <= r_stall_count + 8'd1;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_hazard_stall_ctrl.sv
// ============================================================================
// Module   : tb_hazard_stall_ctrl
// Brief    : Vector-table bench for hazard_stall_ctrl with expected-value queue
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hazard_stall_ctrl;

    logic clk;
    logic rst;

    hazard_stall_ctrl_if #(.ADDR_W(3)) hif ();

    hazard_stall_ctrl #(.ADDR_W(3)) dut (
        .clk (clk),
        .rst (rst),
        .hif (hif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [8*12-1:0] name;
        logic            rst;
        logic            valid;
        logic [2:0]      rs;
        logic            rsu;
        logic [2:0]      rt;
        logic            rtu;
        logic [2:0]      wr;
        logic            wen;
        logic            ld;
        logic            fl;
        logic            pe;
        logic            bub;
        logic [7:0]      cnt;
        logic [1:0]      fs;
        logic [1:0]      ft;
    } vec_t;

    vec_t tbl[$];
    vec_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    function automatic vec_t mk(
        input logic [8*12-1:0] name,
        input logic r, input logic v,
        input logic [2:0] rs, input logic rsu,
        input logic [2:0] rt, input logic rtu,
        input logic [2:0] wr, input logic wen, input logic ld, input logic fl,
        input logic pe, input logic bub, input logic [7:0] cnt,
        input logic [1:0] fs, input logic [1:0] ft
    );
        vec_t t;
        t.name = name; t.rst = r; t.valid = v;
        t.rs = rs; t.rsu = rsu; t.rt = rt; t.rtu = rtu;
        t.wr = wr; t.wen = wen; t.ld = ld; t.fl = fl;
        t.pe = pe; t.bub = bub; t.cnt = cnt; t.fs = fs; t.ft = ft;
        return t;
    endfunction

    task automatic chk(input logic [8*12-1:0] name, input string what,
                       input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %0s %0s: got %0d expected %0d", name, what, act, exp);
        end
    endtask

    task automatic apply(input vec_t v);
        @(negedge clk);
        rst            = v.rst;
        hif.id_valid   = v.valid;
        hif.id_rs      = v.rs;
        hif.id_rs_used = v.rsu;
        hif.id_rt      = v.rt;
        hif.id_rt_used = v.rtu;
        hif.id_wr_reg  = v.wr;
        hif.id_wr_en   = v.wen;
        hif.id_is_load = v.ld;
        hif.flush      = v.fl;
        exp_q.push_back(v);
    endtask

    // Outputs are combinational; compare mid-low-phase, well clear of the edge
    initial begin
        vec_t e;
        forever begin
            @(negedge clk);
            #2;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk(e.name, "pipe_enable", {7'd0, hif.pipe_enable}, {7'd0, e.pe});
                chk(e.name, "bubble",      {7'd0, hif.bubble},      {7'd0, e.bub});
                chk(e.name, "stall_count", hif.stall_count,         e.cnt);
                chk(e.name, "fwd_rs_sel",  {6'd0, hif.fwd_rs_sel},  {6'd0, e.fs});
                chk(e.name, "fwd_rt_sel",  {6'd0, hif.fwd_rt_sel},  {6'd0, e.ft});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        int e;
        rst            = 1'b1;
        hif.id_valid   = 1'b0;
        hif.id_rs      = '0;
        hif.id_rs_used = 1'b0;
        hif.id_rt      = '0;
        hif.id_rt_used = 1'b0;
        hif.id_wr_reg  = '0;
        hif.id_wr_en   = 1'b0;
        hif.id_is_load = 1'b0;
        hif.flush      = 1'b0;
        repeat (2) @(posedge clk);

`ifndef HAZARD_STALL_FWD_EN
        //                  name            rst v  rs  rsu rt  rtu wr  wen ld fl  pe bub cnt
        tbl.push_back(mk("idle",          0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
        tbl.push_back(mk("no_writers",    0, 1, 1, 1, 2, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0));
        tbl.push_back(mk("wr_r3",         0, 1, 0, 0, 0, 0, 3, 1, 0, 0, 1, 0, 0, 0, 0));
        tbl.push_back(mk("raw_ex",        0, 1, 3, 1, 0, 0, 4, 1, 0, 0, 0, 1, 0, 0, 0));
        tbl.push_back(mk("raw_mem",       0, 1, 3, 1, 0, 0, 4, 1, 0, 0, 0, 1, 1, 0, 0));
        tbl.push_back(mk("raw_wb",        0, 1, 3, 1, 0, 0, 4, 1, 0, 0, 0, 1, 2, 0, 0));
        tbl.push_back(mk("proceed",       0, 1, 3, 1, 0, 0, 4, 1, 0, 0, 1, 0, 3, 0, 0));
        tbl.push_back(mk("wr_r5",         0, 1, 0, 0, 0, 0, 5, 1, 0, 0, 1, 0, 3, 0, 0));
        tbl.push_back(mk("nop",           0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 3, 0, 0));
        tbl.push_back(mk("rt_unused",     0, 1, 4, 0, 5, 0, 0, 0, 0, 0, 1, 0, 3, 0, 0));
        tbl.push_back(mk("self_dep",      0, 1, 6, 1, 0, 0, 6, 1, 0, 0, 1, 0, 3, 0, 0));
        tbl.push_back(mk("flush_hazard",  0, 1, 6, 1, 0, 0, 7, 1, 0, 1, 1, 1, 3, 0, 0));
        tbl.push_back(mk("rt_mem",        0, 1, 0, 0, 6, 1, 0, 0, 0, 0, 0, 1, 3, 0, 0));
        tbl.push_back(mk("rt_wb",         0, 1, 0, 0, 6, 1, 0, 0, 0, 0, 0, 1, 4, 0, 0));
        tbl.push_back(mk("rt_clear",      0, 1, 0, 0, 6, 1, 0, 0, 0, 0, 1, 0, 5, 0, 0));
        tbl.push_back(mk("wr_r2",         0, 1, 0, 0, 0, 0, 2, 1, 0, 0, 1, 0, 5, 0, 0));
        tbl.push_back(mk("stall1",        0, 1, 2, 1, 0, 0, 0, 0, 0, 0, 0, 1, 5, 0, 0));
        tbl.push_back(mk("stall2_rst",    1, 1, 2, 1, 0, 0, 0, 0, 0, 0, 0, 1, 6, 0, 0));
        tbl.push_back(mk("after_rst",     0, 1, 2, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
        tbl.push_back(mk("wr_r1",         0, 1, 0, 0, 0, 0, 1, 1, 0, 0, 1, 0, 0, 0, 0));
        tbl.push_back(mk("invalid_id",    0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
        tbl.push_back(mk("rt_hit_mem",    0, 1, 7, 1, 1, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0));
        tbl.push_back(mk("drain",         0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0));
        for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);

        // Hazards cap at 3 in a row (bubbles drain the scoreboard), so repeat
        // writer + 3 dependent reads until the counter has seen 301 stalls.
        e = 1;
        for (int i = 0; i < 100; i++) begin
            apply(mk("sat_wr", 0, 1, 0, 0, 0, 0, 1, 1, 0, 0, 1, 0, e[7:0], 0, 0));
            for (int k = 0; k < 3; k++) begin
                apply(mk("sat_rd", 0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1, e[7:0], 0, 0));
                if (e < 255) e++;
            end
        end
        apply(mk("sat_hold", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 8'd255, 0, 0));
`else
        tbl.push_back(mk("ld_r2",         0, 1, 0, 0, 0, 0, 2, 1, 1, 0, 1, 0, 0, 0, 0));
        tbl.push_back(mk("load_use",      0, 1, 2, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
        tbl.push_back(mk("fwd_mem",       0, 1, 2, 1, 0, 0, 2, 1, 0, 0, 1, 0, 1, 2, 0));
        tbl.push_back(mk("fwd_ex_wb",     0, 1, 2, 1, 2, 1, 0, 0, 0, 0, 1, 0, 1, 1, 1));
        tbl.push_back(mk("fwd_mem_rt",    0, 1, 0, 0, 2, 1, 0, 0, 0, 0, 1, 0, 1, 0, 2));
        tbl.push_back(mk("fwd_idle",      0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0));
        for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);
`endif

        repeat (3) @(posedge clk);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL queue_drain: %0d entries left, expected 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
